// File: rtl/ffe_pkg.sv
// ffe_pkg: shared defaults, counter width and fixed-point round/saturate helpers for the FFE core
package ffe_pkg;
    localparam int DEF_LANES = 4;
    localparam int DEF_TAPS = 14;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 8;
    localparam int DEF_FRAC = 6;
    localparam int SATW = 16;

    // Round half up by adding 2^(frac-1), then drop frac bits with an arithmetic shift
    function automatic logic signed [63:0] rnd(input logic signed [63:0] v, input int frac);
        return frac > 0 ? (v + (64'sd1 <<< (frac - 1))) >>> frac : v;
    endfunction

    // True when the rounded value falls outside the dw-bit signed range
    function automatic logic is_sat(input logic signed [63:0] v, input int frac, input int dw);
        return rnd(v, frac) > (64'sd1 <<< (dw - 1)) - 64'sd1 || rnd(v, frac) < -(64'sd1 <<< (dw - 1));
    endfunction

    // Rounded value clamped to the dw-bit signed range, sign-extended to 64 bits
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v, input int frac, input int dw);
        logic signed [63:0] r;
        r = rnd(v, frac);
        return is_sat(v, frac, dw) ? (r < 0 ? -(64'sd1 <<< (dw - 1)) : (64'sd1 <<< (dw - 1)) - 64'sd1) : r;
    endfunction
endpackage

// File: rtl/ffe_lane.sv
// ffe_lane: one lane's delay line, full-precision MAC (S1) and round/saturate output register (S2)
module ffe_lane import ffe_pkg::*; #(
    parameter int TAPS = DEF_TAPS,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 shift_i,
    input  logic                 s1_en_i,
    input  logic                 s2_en_i,
    input  logic                 flush_i,
    input  logic                 bypass_i,
    input  logic signed [DW-1:0] din_i,
    input  logic [TAPS*CW-1:0]   coef_i,
    output logic [DW-1:0]        dout_o,
    output logic                 sat_o
);
    localparam int AW = DW + CW + $clog2(TAPS);

    // x_q holds the older samples only; the newest one is the sample being accepted
    logic signed [DW-1:0] x_q [TAPS-1];
    logic signed [DW-1:0] xn [TAPS];
    logic signed [AW-1:0] acc_d, acc_q;
    logic signed [DW-1:0] x0_q, dout_q;
    logic                 byp_q, sat_q;

    assign dout_o = dout_q;
    assign sat_o = sat_q;

    // Window with the incoming sample in front and its dot product with the active taps
    always_comb begin
        acc_d = '0;
        xn[0] = din_i;
        for (int i = 1; i < TAPS; i++) xn[i] = x_q[i-1];
        for (int i = 0; i < TAPS; i++) acc_d = acc_d + AW'(xn[i]) * AW'($signed(coef_i[i*CW +: CW]));
    end

    // History shift on accept, S1 capture of the sum, S2 rounding/saturation or bypass
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '{default: '0};
            acc_q <= '0;
            x0_q <= '0;
            byp_q <= 1'b0;
            dout_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (flush_i) x_q <= '{default: '0};
            else if (shift_i) for (int i = 0; i < TAPS - 1; i++) x_q[i] <= xn[i];
            if (s1_en_i) begin
                acc_q <= acc_d;
                x0_q <= din_i;
                byp_q <= bypass_i;
            end
            if (s2_en_i) begin
                dout_q <= byp_q ? x0_q : DW'(round_sat(64'(acc_q), FRAC, DW));
                sat_q <= ~byp_q & is_sat(64'(acc_q), FRAC, DW);
            end
        end
    end
endmodule

// File: rtl/ffe_param_core.sv
// ffe_param_core: multi-lane FIR equalizer with ready/valid streaming, shadowed coefficient banks and a saturation counter
module ffe_param_core import ffe_pkg::*; #(
    parameter int LANES = DEF_LANES,
    parameter int TAPS = DEF_TAPS,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW,
    parameter int FRAC = DEF_FRAC,
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1,
    localparam int IW = $clog2(TAPS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic [LANES*DW-1:0] io_in_bits,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [LANES*DW-1:0] io_out_bits,
    input  logic                coef_we,
    input  logic [LW-1:0]       coef_lane,
    input  logic [IW-1:0]       coef_idx,
    input  logic [CW-1:0]       coef_data,
    input  logic                coef_commit,
    input  logic                bypass,
    input  logic                flush,
    input  logic                sat_clear,
    output logic [SATW-1:0]     sat_count
);
    typedef logic [LANES-1:0][TAPS-1:0][CW-1:0] bank_t;
    localparam logic [CW-1:0] ONE = CW'(1 << FRAC);
    localparam bank_t IDENT = {LANES{{((TAPS - 1) * CW){1'b0}}, ONE}};

    bank_t           shadow_q, shadow_d, active_q, active_d;
    logic            s1_v_q, out_v_q, stall, accept;
    logic [SATW-1:0] sat_q, sat_d;
    logic [LANES-1:0] lane_sat;

    assign stall = out_v_q & ~io_out_ready;
    assign io_in_ready = ~stall;
    assign accept = io_in_valid & io_in_ready;
    assign io_out_valid = out_v_q;
    assign sat_count = sat_q;

    // Shadow write, commit of the shadow including a same-cycle write, and saturating counter update
    always_comb begin
        shadow_d = shadow_q;
        if (coef_we && int'(coef_lane) < LANES && int'(coef_idx) < TAPS) shadow_d[coef_lane][coef_idx] = coef_data;
        active_d = coef_commit ? shadow_d : active_q;
        sat_d = sat_clear ? '0 : (out_v_q && io_out_ready && |lane_sat && ~&sat_q) ? sat_q + SATW'(1) : sat_q;
    end

    // Stage valids advance together unless the output is stalled; flush empties both stages
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q <= 1'b0;
            out_v_q <= 1'b0;
            sat_q <= '0;
            shadow_q <= IDENT;
            active_q <= IDENT;
        end else begin
            s1_v_q <= flush ? 1'b0 : stall ? s1_v_q : accept;
            out_v_q <= flush ? 1'b0 : stall ? out_v_q : s1_v_q;
            sat_q <= sat_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ffe_lane #(.TAPS(TAPS), .DW(DW), .CW(CW), .FRAC(FRAC)) u_lane (
            .clock(clock),
            .reset(reset),
            .shift_i(accept & ~flush),
            .s1_en_i(~stall),
            .s2_en_i(~stall & s1_v_q),
            .flush_i(flush),
            .bypass_i(bypass),
            .din_i(io_in_bits[k*DW +: DW]),
            .coef_i(active_q[k]),
            .dout_o(io_out_bits[k*DW +: DW]),
            .sat_o(lane_sat[k])
        );
    end
endmodule

// File: tb/tb_ffe_param_core.sv
// tb_ffe_param_core: table-driven and scoreboard-checked bench for the FFE core at default parameters
module tb_ffe_param_core;
    logic        clock = 1'b0, reset = 1'b1;
    logic        io_in_valid = 1'b0, io_out_ready = 1'b1;
    logic        coef_we = 1'b0, coef_commit = 1'b0, bypass = 1'b0, flush = 1'b0, sat_clear = 1'b0;
    logic [31:0] io_in_bits = '0;
    logic [1:0]  coef_lane = '0;
    logic [3:0]  coef_idx = '0;
    logic [7:0]  coef_data = '0;
    logic        io_in_ready, io_out_valid;
    logic [31:0] io_out_bits;
    logic [15:0] sat_count;
    int          total = 0, bad = 0;
    bit          rnd = 1'b0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic signed [7:0] x;
        logic              byp;
        logic signed [7:0] e0;
        logic signed [7:0] e1;
    } vec_t;

    ffe_param_core dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
        .coef_we(coef_we), .coef_lane(coef_lane), .coef_idx(coef_idx), .coef_data(coef_data),
        .coef_commit(coef_commit), .bypass(bypass), .flush(flush), .sat_clear(sat_clear),
        .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd) io_out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send(input logic [31:0] bits, input logic [31:0] e, input bit push);
        int n = 0;
        io_in_valid = 1'b1;
        io_in_bits = bits;
        while (!io_in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!io_in_ready) chk("in_ready_timeout", 32'(io_in_ready), 32'd1);
        else if (push) exp_q.push_back(e);
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic wcoef(input logic [1:0] l, input logic [3:0] i, input logic [7:0] d, input logic c);
        coef_we = 1'b1;
        coef_lane = l;
        coef_idx = i;
        coef_data = d;
        coef_commit = c;
        tick();
        coef_we = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    // Scoreboard: every presented beat must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && io_out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%h want=none", io_out_bits);
            end else if (io_out_ready) chk("out_beat", io_out_bits, exp_q.pop_front());
            else chk("held_out", io_out_bits, exp_q[0]);
        end
    end

    initial begin
        vec_t tbl [9];
        logic [7:0] v;
        tbl[0] = '{8'sd64, 1'b0, 8'sd64, 8'sd64};
        tbl[1] = '{8'sd0, 1'b0, 8'sd32, 8'sd0};
        tbl[2] = '{8'sd0, 1'b0, 8'sd16, 8'sd0};
        tbl[3] = '{8'sd0, 1'b0, 8'sd0, 8'sd0};
        tbl[4] = '{8'sd10, 1'b1, 8'sd10, 8'sd10};
        tbl[5] = '{-8'sd20, 1'b0, -8'sd15, -8'sd20};
        tbl[6] = '{8'sd3, 1'b1, 8'sd3, 8'sd3};
        tbl[7] = '{8'sd1, 1'b0, -8'sd2, 8'sd1};
        tbl[8] = '{8'sd0, 1'b0, 8'sd1, 8'sd0};
        #3;
        chk("rst_out_valid", 32'(io_out_valid), 32'd0);
        chk("rst_out_bits", io_out_bits, 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(io_in_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        // impulse response on lane 0 (taps 64,32,16), identity elsewhere, with bypass beats mixed in
        wcoef(2'd0, 4'd1, 8'd32, 1'b0);
        wcoef(2'd0, 4'd2, 8'd16, 1'b1);
        for (int i = 0; i < 9; i++) begin
            bypass = tbl[i].byp;
            send({tbl[i].x, tbl[i].x, tbl[i].x, tbl[i].x}, {tbl[i].e1, tbl[i].e1, tbl[i].e1, tbl[i].e0}, 1'b1);
            bypass = 1'b0;
            if (i == 0) begin
                chk("latency_cycle1", 32'(io_out_valid), 32'd0);
                tick();
                chk("latency_cycle2", 32'(io_out_valid), 32'd1);
            end
        end
        drain();
        // commit in the accept cycle affects only later beats; write+commit together includes the write
        do_reset();
        wcoef(2'd0, 4'd0, 8'd32, 1'b0);
        coef_commit = 1'b1;
        send(32'h40404040, 32'h40404040, 1'b1);
        coef_commit = 1'b0;
        send(32'h40404040, 32'h40404020, 1'b1);
        wcoef(2'd1, 4'd0, 8'd32, 1'b1);
        send(32'h40404040, 32'h40402020, 1'b1);
        drain();
        // saturation at both rails, count held by sat_clear, count restarts afterwards
        do_reset();
        wcoef(2'd0, 4'd0, 8'd127, 1'b1);
        send(32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1);
        drain();
        chk("sat_count_pos", 32'(sat_count), 32'd1);
        send(32'h80808080, 32'h80808080, 1'b1);
        drain();
        chk("sat_count_neg", 32'(sat_count), 32'd2);
        send(32'h00000000, 32'h00000000, 1'b1);
        drain();
        chk("sat_count_nosat", 32'(sat_count), 32'd2);
        sat_clear = 1'b1;
        send(32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1);
        drain();
        tick();
        chk("sat_clear_priority", 32'(sat_count), 32'd0);
        sat_clear = 1'b0;
        send(32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1);
        drain();
        chk("sat_count_after_clear", 32'(sat_count), 32'd1);
        // reset with two beats in flight drops them and restores identity taps
        send(32'h7f7f7f7f, 32'h0, 1'b0);
        send(32'h7f7f7f7f, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(io_out_valid), 32'd0);
        chk("midrst_sat_count", 32'(sat_count), 32'd0);
        chk("midrst_in_ready", 32'(io_in_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        send(32'h05050505, 32'h05050505, 1'b1);
        drain();
        // flush drops the in-flight beat and the flush-cycle input, and zeroes history
        wcoef(2'd0, 4'd1, 8'd64, 1'b1);
        send(32'h07070707, 32'h0, 1'b0);
        flush = 1'b1;
        io_in_valid = 1'b1;
        io_in_bits = 32'h09090909;
        tick();
        flush = 1'b0;
        io_in_valid = 1'b0;
        tick();
        tick();
        chk("flush_out_valid", 32'(io_out_valid), 32'd0);
        send(32'h05050505, 32'h05050505, 1'b1);
        send(32'h03030303, 32'h03030308, 1'b1);
        drain();
        // ordered streaming under random backpressure
        do_reset();
        rnd = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            v = 8'(i);
            send({4{v}}, {4{v}}, 1'b1);
        end
        drain();
        rnd = 1'b0;
        io_out_ready = 1'b1;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ffe_param_core.md
FFE_PARAM_CORE -- requirements
Module: ffe_param_core

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent lanes.
REQ-002 SHALL have parameter TAPS, default 14, FIR taps per lane (2..32).
REQ-003 SHALL have parameter DW, default 8, signed sample width in and out.
REQ-004 SHALL have parameter CW, default 8, signed coefficient width.
REQ-005 SHALL have parameter FRAC, default 6, coefficient fractional bits.
REQ-006 SHALL have ports: clock in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: io_in_valid in 1; io_in_ready out 1; io_in_bits in LANES*DW, lane k at bits [k*DW +: DW].
REQ-008 SHALL have ports: io_out_valid out 1; io_out_ready in 1; io_out_bits out LANES*DW.
REQ-009 SHALL have ports: coef_we in 1; coef_lane in clog2(LANES); coef_idx in clog2(TAPS); coef_data in CW; coef_commit in 1.
REQ-010 SHALL have ports: bypass in 1; flush in 1; sat_clear in 1; sat_count out 16.

Function
REQ-011 SHALL accept an input beat when io_in_valid && io_in_ready, and emit an output beat when io_out_valid && io_out_ready.
REQ-012 SHALL form a two-stage pipeline (S1 multiply/sum, S2 round/saturate/output), giving 2-cycle latency from accept to io_out_valid with io_out_ready held high.
REQ-013 SHALL stall both stages when io_out_valid && !io_out_ready; io_in_ready = !(io_out_valid && !io_out_ready); held output data SHALL stay stable while stalled.
REQ-014 SHALL keep per-lane delay line x[0..TAPS-1] that shifts only on input accept; x[0] = newest sample.
REQ-015 SHALL compute y = sum over i of x[i]*c_active[lane][i] at full precision (DW+CW+clog2(TAPS) bits).
REQ-016 SHALL round by adding 2^(FRAC-1), then arithmetic-shift right by FRAC, then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-017 SHALL increment sat_count once per output beat in which any lane saturated; sat_count SHALL hold at 0xFFFF.
REQ-018 SHALL clear sat_count on sat_clear; sat_clear takes priority over a simultaneous increment.
REQ-019 SHALL write coef_data to shadow[coef_lane][coef_idx] on coef_we; out-of-range lane/idx writes SHALL be ignored.
REQ-020 SHALL copy shadow to active on coef_commit; the copy applies to beats accepted in the following cycle onward, never to a beat already in S1.
REQ-021 SHALL, on coef_we and coef_commit in the same cycle, commit the shadow including that write.
REQ-022 SHALL, with bypass=1, output x[0] of each lane unchanged at the same 2-cycle latency; bypass SHALL be sampled at input accept and travel with the beat.
REQ-023 SHALL, on flush, zero all delay lines and invalidate S1/S2 in one cycle; coefficients and sat_count SHALL be kept; an input accepted in the flush cycle SHALL be discarded.

Reset
REQ-024 SHALL asynchronously clear on reset: io_out_valid=0, io_out_bits=0, sat_count=0, delay lines=0, pipeline valids=0.
REQ-025 SHALL reset active and shadow coefficients to identity: tap 0 = 2^FRAC, all other taps 0; io_in_ready SHALL read 1 after reset.
REQ-026 SHALL, on reset assertion mid-stream, drop in-flight beats with no partial output after release.

Structure
REQ-027 SHALL place LANES/TAPS/DW/CW/FRAC defaults, the sat_count width, and the round/saturate function in package ffe_pkg.
REQ-028 SHALL use one sub-module ffe_lane (delay line, MAC, round/saturate) instantiated LANES times; the top SHALL hold the handshake, coefficient banks and sat_count.

Verification
REQ-029 SHALL test impulse response: set lane 0 taps to 64,32,16,0.. (FRAC=6), commit, drive 64 then zeros -> outputs 64,32,16,0 starting 2 cycles after first accept.
REQ-030 SHALL test saturation: identity taps, change tap0 to 127, feed 127 -> output 127, sat_count=1; feed -128 -> -128, sat_count=2.
REQ-031 SHALL test backpressure: stream 1..20 with io_out_ready toggled randomly -> outputs in order with no loss or duplication, stable while stalled.
REQ-032 SHALL test commit timing: commit tap0=32 in the same cycle a beat of 64 is accepted -> that beat outputs 64, the next beat of 64 outputs 32.
REQ-033 SHALL test reset/flush: assert reset with two beats in flight -> io_out_valid=0 and sat_count=0; after release, identity passthrough of 5 -> 5; flush mid-stream -> next output uses a zeroed history.
